// File: rtl/secp256k1_pdbl_seq.sv
// Jacobian point doubling (a=0, dbl-2009-l) for secp256k1, sequenced as 21 field ops
// issued one at a time to an external shared ADD/SUB/MUL ALU.
module secp256k1_pdbl_seq #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] x_in,
  input  logic [255:0] y_in,
  input  logic [255:0] z_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [255:0] x_out,
  output logic [255:0] y_out,
  output logic [255:0] z_out,
  output logic         alu_start,
  output logic [1:0]   alu_op,
  output logic [255:0] alu_a,
  output logic [255:0] alu_b,
  input  logic [255:0] alu_result,
  input  logic         alu_done
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_FIN} state_t;
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] dst;
    logic [2:0] s1;
    logic [2:0] s2;
  } uop_t;

  // Register map: 0=X 1=Y 2=Z 3=T0 4=T1 5=T2 6=T3; op 0=ADD 1=SUB 2=MUL
  function automatic uop_t rom(input logic [4:0] pc);
    case (pc)
      5'd0:    return {2'd2, 3'd3, 3'd0, 3'd0};
      5'd1:    return {2'd2, 3'd4, 3'd1, 3'd1};
      5'd2:    return {2'd2, 3'd5, 3'd4, 3'd4};
      5'd3:    return {2'd0, 3'd4, 3'd0, 3'd4};
      5'd4:    return {2'd2, 3'd4, 3'd4, 3'd4};
      5'd5:    return {2'd1, 3'd4, 3'd4, 3'd3};
      5'd6:    return {2'd1, 3'd4, 3'd4, 3'd5};
      5'd7:    return {2'd0, 3'd4, 3'd4, 3'd4};
      5'd8:    return {2'd0, 3'd6, 3'd3, 3'd3};
      5'd9:    return {2'd0, 3'd3, 3'd6, 3'd3};
      5'd10:   return {2'd2, 3'd6, 3'd3, 3'd3};
      5'd11:   return {2'd2, 3'd2, 3'd1, 3'd2};
      5'd12:   return {2'd0, 3'd2, 3'd2, 3'd2};
      5'd13:   return {2'd1, 3'd0, 3'd6, 3'd4};
      5'd14:   return {2'd1, 3'd0, 3'd0, 3'd4};
      5'd15:   return {2'd1, 3'd6, 3'd4, 3'd0};
      5'd16:   return {2'd2, 3'd6, 3'd3, 3'd6};
      5'd17:   return {2'd0, 3'd5, 3'd5, 3'd5};
      5'd18:   return {2'd0, 3'd5, 3'd5, 3'd5};
      5'd19:   return {2'd0, 3'd5, 3'd5, 3'd5};
      5'd20:   return {2'd1, 3'd1, 3'd6, 3'd5};
      default: return '0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [255:0]     res_q, res_d;
  logic [255:0]     rf_q [7];
  logic [255:0]     rf_d [7];
  logic [255:0]     x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic             done_q, done_d, error_q, error_d;
  uop_t             uop;
  logic             op_active;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rf_d    = rf_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    uop     = rom(pc_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rf_d[0] = x_in;
          rf_d[1] = y_in;
          rf_d[2] = z_in;
          pc_d    = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the last allowed cycle still wins over the abort
        if (alu_done) begin
          res_d   = alu_result;
          state_d = S_WRITE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        rf_d[uop.dst] = res_q;
        pc_d          = pc_q + 5'd1;
        state_d       = (pc_q == 5'd20) ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        x_out_d = rf_q[0];
        y_out_d = rf_q[1];
        z_out_d = rf_q[2];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      for (int i = 0; i < 7; i++) rf_q[i] <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rf_q    <= rf_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Operands are only presented while an op is in flight, so idle/reset shows zeros
  assign op_active = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign alu_start = (state_q == S_ISSUE);
  assign alu_op    = op_active ? uop.op : 2'b00;
  assign alu_a     = op_active ? rf_q[uop.s1] : '0;
  assign alu_b     = op_active ? rf_q[uop.s2] : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;

endmodule

// File: tb/tb_secp256k1_pdbl_seq.sv
// Scoreboard bench for secp256k1_pdbl_seq with a behavioural mod-p ALU and a reference doubling.
module tb_secp256k1_pdbl_seq;

  localparam int TMO = 4096;
  localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] x_in = '0, y_in = '0, z_in = '0;
  logic         busy, done, error, alu_start, alu_done;
  logic [255:0] x_out, y_out, z_out, alu_a, alu_b, alu_result;
  logic [1:0]   alu_op;

  secp256k1_pdbl_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done), .error(error),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int ops_seen = 0;
  int cyc = 0;
  int t_start = 0;
  bit stuck = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] x, y, z;
    logic         err;
    int           nops;
  } exp_t;
  exp_t sbq[$];
  logic [255:0] last_x = '0, last_y = '0, last_z = '0;
  logic [1:0] exp_op [21] = '{2, 2, 2, 0, 2, 1, 1, 0, 0, 0, 2, 2, 0, 1, 1, 1, 2, 0, 0, 0, 1};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'b0, a} * {256'b0, b};
    t = t % {256'b0, P};
    return t[255:0];
  endfunction

  // Textbook Jacobian doubling: S=4XY^2, M=3X^2, X3=M^2-2S, Y3=M(S-X3)-8Y^4, Z3=2YZ
  task automatic pdbl_ref(input logic [255:0] x, y, z, output logic [255:0] x3, y3, z3);
    logic [255:0] yy, s, m, y4;
    yy = fmul(y, y);
    s  = fmul(fadd(fadd(x, x), fadd(x, x)), yy);
    m  = fmul(fadd(fadd(x, x), x), x);
    x3 = fsub(fmul(m, m), fadd(s, s));
    y4 = fmul(yy, yy);
    y4 = fadd(y4, y4); y4 = fadd(y4, y4); y4 = fadd(y4, y4);
    y3 = fsub(fmul(m, fsub(s, x3)), y4);
    z3 = fmul(fadd(y, y), z);
  endtask

  // Behavioural ALU: random 1..4 cycle latency, or silent when stuck
  initial begin : alu_model
    bit           pend;
    int           cnt;
    logic [1:0]   l_op;
    logic [255:0] l_a, l_b, l_r;
    pend = 1'b0; cnt = 0;
    alu_done = 1'b0; alu_result = '0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            check("hold_op", 256'(alu_op), 256'(l_op));
            check("hold_a", alu_a, l_a);
            check("hold_b", alu_b, l_b);
            alu_result = l_r;
            alu_done = 1'b1;
            pend = 1'b0;
          end
        end
        if (alu_start) begin
          if (ops_seen < 21) check($sformatf("op%0d", ops_seen + 1), 256'(alu_op), 256'(exp_op[ops_seen]));
          ops_seen++;
          t_start = cyc;
          l_op = alu_op; l_a = alu_a; l_b = alu_b;
          case (alu_op)
            2'd0:    l_r = fadd(alu_a, alu_b);
            2'd1:    l_r = fsub(alu_a, alu_b);
            2'd2:    l_r = fmul(alu_a, alu_b);
            default: l_r = '0;
          endcase
          cnt = $urandom_range(4, 1);
          pend = !stuck;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 256'(1), 256'(0));
        end else begin
          e = sbq.pop_front();
          check("x_out", x_out, e.x);
          check("y_out", y_out, e.y);
          check("z_out", z_out, e.z);
          check("error", 256'(error), 256'(e.err));
          check("busy_at_done", 256'(busy), 256'(0));
          check("op_count", 256'(ops_seen), 256'(e.nops));
          if (e.err) check("tmo_latency", 256'(cyc - t_start), 256'(TMO));
        end
        n_done++;
      end
    end
  end

  task automatic run(input logic [255:0] x, y, z, input bit err, input int nops);
    exp_t e;
    if (err) begin
      e.x = last_x; e.y = last_y; e.z = last_z;
    end else begin
      pdbl_ref(x, y, z, e.x, e.y, e.z);
      last_x = e.x; last_y = e.y; last_z = e.z;
    end
    e.err = err;
    e.nops = nops;
    sbq.push_back(e);
    x_in = x; y_in = y; z_in = z;
    ops_seen = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 256'(busy), 256'(1));
  endtask

  task automatic wait_done(input int budget);
    int b0;
    int i;
    b0 = n_done;
    i = 0;
    while (n_done == b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (n_done == b0) check("done_wait_expired", 256'(0), 256'(1));
  endtask

  task automatic wait_ops(input int n, input int budget);
    int i;
    i = 0;
    while (ops_seen < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (ops_seen < n) check("ops_wait_expired", 256'(ops_seen), 256'(n));
  endtask

  task automatic check_zero(input string p);
    check({p, "_busy"}, 256'(busy), 256'(0));
    check({p, "_done"}, 256'(done), 256'(0));
    check({p, "_error"}, 256'(error), 256'(0));
    check({p, "_x_out"}, x_out, '0);
    check({p, "_y_out"}, y_out, '0);
    check({p, "_z_out"}, z_out, '0);
    check({p, "_alu_start"}, 256'(alu_start), 256'(0));
    check({p, "_alu_op"}, 256'(alu_op), 256'(0));
    check({p, "_alu_a"}, alu_a, '0);
    check({p, "_alu_b"}, alu_b, '0);
  endtask

  initial begin : main
    logic [255:0] ez, x2, y2, z2;
    int n0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Generator doubling, checked against the known affine 2G
    run(GX, GY, 256'd1, 1'b0, 21);
    wait_done(2000);
    ez = fadd(GY, GY);
    check("t1_z3", z_out, ez);
    check("t1_x3_affine", x_out, fmul(G2X, fmul(ez, ez)));
    check("t1_y3_affine", y_out, fmul(G2Y, fmul(ez, fmul(ez, ez))));

    // Points at infinity
    run(256'd5, 256'd0, 256'd1, 1'b0, 21);
    wait_done(2000);
    check("t3_z_y0", z_out, '0);
    run(GX, GY, 256'd0, 1'b0, 21);
    wait_done(2000);
    check("t3_z_z0", z_out, '0);

    // ALU never answers: timeout, then a normal run
    stuck = 1'b1;
    run(GX, GY, 256'd1, 1'b1, 1);
    wait_done(TMO + 200);
    stuck = 1'b0;
    run(GX, GY, 256'd1, 1'b0, 21);
    wait_done(2000);

    // Asynchronous reset in the middle of op 12
    run(GX, GY, 256'd1, 1'b0, 21);
    wait_ops(12, 2000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    sbq.delete();
    last_x = '0; last_y = '0; last_z = '0;
    n0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", 256'(n_done - n0), 256'(0));
    run(GX, GY, 256'd1, 1'b0, 21);
    wait_done(2000);

    // start pulsed while waiting on op 5 is ignored, then 2G -> 4G back-to-back
    run(GX, GY, 256'd1, 1'b0, 21);
    wait_ops(5, 2000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    x2 = last_x; y2 = last_y; z2 = last_z;
    run(x2, y2, z2, 1'b0, 21);
    wait_done(2000);
    repeat (10) @(negedge clk);
    check("sb_empty", 256'(sbq.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
